mem_buffer_arbiter: RTL and testbench
=====================================

# mem_buffer_arbiter

Shares the single-port 256x16 memory buffer among NUM_REQ requesters. Each requester issues one read or write per handshake; the block arbitrates round-robin, supports locked bursts, and drives the buffer's Read/Write/Address/Write_Data port with registered outputs. Read data is returned to the originating requester with an ID tag and a fixed latency. The block sits between client engines and the buffer instance.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 8, buffer address width
- DATA_W, 16, buffer data width
- Clk  in  1  clock
- Rst  in  1  reset, synchronous, active-high
- Req_Valid  in  NUM_REQ  per-requester request valid
- Req_Write  in  NUM_REQ  1 = write, 0 = read
- Req_Lock  in  NUM_REQ  hold the grant after this beat
- Req_Addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- Req_Wdata  in  NUM_REQ*DATA_W  packed write data
- Req_Ready  out  NUM_REQ  one-hot grant; a beat transfers when Valid & Ready
- Rsp_Valid  out  1  read data valid
- Rsp_Id  out  $clog2(NUM_REQ) (min 1)  requester that issued the read
- Rsp_Data  out  DATA_W  read data
- Mem_Read, Mem_Write  out  1  buffer controls
- Mem_Address  out  ADDR_W  buffer address
- Mem_Write_Data  out  DATA_W  buffer write data
- Mem_Read_Data  in  DATA_W  buffer read port

## Operation
- FSM states: ARB_OPEN (arbitrate each cycle), ARB_LOCKED (grant pinned to lock owner).
- ARB_OPEN: grant the first valid requester at or after rr pointer, wrapping; on any grant to i, pointer <= (i+1) mod NUM_REQ. If the granted beat has Req_Lock=1, go ARB_LOCKED with owner=i.
- ARB_LOCKED: Req_Ready = owner's Req_Valid only; other requesters get no Ready. Owner beat with Req_Lock=0 returns to ARB_OPEN. Owner dropping Valid keeps lock (no timeout).
- Req_Ready is combinational from Req_Valid, state, pointer; at most one bit set; zero while Rst high.
- Accepted beat registers Mem_Read=~Req_Write, Mem_Write=Req_Write, Mem_Address, Mem_Write_Data next cycle. Mem_Read and Mem_Write never both 1. No beat: both controls 0, address/data hold.
- Read tag pipeline (2 stages) carries valid+ID; Rsp_Data = Mem_Read_Data when Rsp_Valid else 0 (masks buffer's high-Z idle output).
- No response backpressure; requesters must sink Rsp_Valid every cycle.
- Write then read to same address on consecutive beats returns new data (buffer write lands before read issues).

## Timing
- Reset values: Req_Ready 0, Rsp_Valid 0, Rsp_Id 0, Rsp_Data 0, Mem_Read 0, Mem_Write 0, Mem_Address 0, Mem_Write_Data 0, pointer 0, state ARB_OPEN.
- Beat accepted cycle N -> Mem_* valid cycle N+1 -> Rsp_Valid/Rsp_Data cycle N+2 (read latency 2).
- Throughput: one beat per cycle, back-to-back across requesters.
- Rst mid-operation: in-flight tags cleared; no Rsp_Valid for reads accepted before Rst; lock released.
- First grant possible in the cycle after Rst deasserts (buffer contents reloaded during Rst).

## Configuration
- MEM_BUFFER_ARB_PRIO_EN defined: requester 0 has fixed highest priority in ARB_OPEN, then ascending index; pointer unused. Locking unchanged.
- Undefined: round-robin as above.

## Structure
- mem_buffer_pkg: ADDR_W/DATA_W defaults, arb_state_t enum {ARB_OPEN, ARB_LOCKED}, rsp_tag_t struct {valid, id}.
- Sub-module rr_arbiter: NUM_REQ request vector + pointer -> one-hot grant and encoded index; the priority variant lives inside it under the macro.

## Test plan
- Single read: R0 reads addr 0x05 (file value 0x1234) cycle N -> Mem_Read=1, Mem_Address=0x05 at N+1; Rsp_Valid=1, Rsp_Id=0, Rsp_Data=0x1234 at N+2.
- Contention: R0 and R1 valid every cycle, no lock -> grants alternate 0,1,0,1; pointer wraps at NUM_REQ.
- Lock burst: R1 locks for 4 beats while R0 valid -> R0 Ready low for those 4 cycles; R0 granted on the cycle after R1's unlocked beat.
- Write-then-read: R0 writes 0xBEEF to 0x10, next cycle reads 0x10 -> Rsp_Data=0xBEEF two cycles later.
- Reset mid-read: Rst asserted at N+1 after read accepted at N -> Rsp_Valid stays 0; all outputs at reset values; buffer content back to file values.
- MEM_BUFFER_ARB_PRIO_EN build: R0 and R1 continuously valid -> R0 granted every cycle, R1 never.

Source files
------------

// File: rtl/mem_buffer_pkg.sv
// Shared types and defaults for the memory-buffer arbiter slice.
// The MEM_BUFFER_ARB_PRIO_EN macro switches the arbiter to fixed priority.
package mem_buffer_pkg;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 16;
    localparam int MAX_REQ    = 8;
    localparam int TAG_ID_W   = 3;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } rsp_tag_t;

endpackage

// File: rtl/mem_buffer_arbiter_rr_arbiter.sv
// Request vector to one-hot grant plus encoded index.
// Round-robin from ptr_i by default; fixed priority (index 0 first) under MEM_BUFFER_ARB_PRIO_EN.
module rr_arbiter
    import mem_buffer_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o
);

`ifdef MEM_BUFFER_ARB_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                gnt_o    = '0;
                gnt_o[k] = 1'b1;
                idx_o    = IDX_W'(k);
            end
        end
    end
`else
    always_comb begin
        logic       found;
        logic [IDX_W:0] cand;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        // Scan forward from the pointer, wrapping at NUM_REQ
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_i} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(NUM_REQ)) begin
                cand = cand - (IDX_W + 1)'(NUM_REQ);
            end
            if (!found && req_i[cand[IDX_W-1:0]]) begin
                found                  = 1'b1;
                gnt_o[cand[IDX_W-1:0]] = 1'b1;
                idx_o                  = cand[IDX_W-1:0];
            end
        end
    end
`endif

endmodule

// File: rtl/mem_buffer_arbiter.sv
// Arbitrates NUM_REQ requesters onto the single-port 256x16 buffer with locked bursts
// and a two-stage read tag pipeline. Build option: MEM_BUFFER_ARB_PRIO_EN (fixed priority).
module mem_buffer_arbiter
    import mem_buffer_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    parameter  int ADDR_W  = MEM_ADDR_W,
    parameter  int DATA_W  = MEM_DATA_W,
    localparam int ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [NUM_REQ-1:0]         Req_Valid,
    input  logic [NUM_REQ-1:0]         Req_Write,
    input  logic [NUM_REQ-1:0]         Req_Lock,
    input  logic [NUM_REQ*ADDR_W-1:0]  Req_Addr,
    input  logic [NUM_REQ*DATA_W-1:0]  Req_Wdata,
    output logic [NUM_REQ-1:0]         Req_Ready,
    output logic                       Rsp_Valid,
    output logic [ID_W-1:0]            Rsp_Id,
    output logic [DATA_W-1:0]          Rsp_Data,
    output logic                       Mem_Read,
    output logic                       Mem_Write,
    output logic [ADDR_W-1:0]          Mem_Address,
    output logic [DATA_W-1:0]          Mem_Write_Data,
    input  logic [DATA_W-1:0]          Mem_Read_Data
);

    arb_state_t        state_q;
    logic [ID_W-1:0]   owner_q;
    logic [ID_W-1:0]   ptr_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    rsp_tag_t          tag_p1_q;
    rsp_tag_t          tag_p2_q;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]    arb_idx;
    logic [ID_W-1:0]    gnt_idx;
    logic               beat;
    logic               sel_write;
    logic               sel_lock;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_rr_arbiter (
        .req_i   (Req_Valid),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx)
    );

    // Grant decode: a lock pins Ready to the owner's own Valid
    always_comb begin
        Req_Ready = '0;
        if (!Rst) begin
            if (state_q == ARB_LOCKED) begin
                Req_Ready[owner_q] = Req_Valid[owner_q];
            end else begin
                Req_Ready = arb_gnt;
            end
        end
    end

    assign gnt_idx   = (state_q == ARB_LOCKED) ? owner_q : arb_idx;
    assign beat      = |(Req_Valid & Req_Ready);
    assign sel_write = Req_Write[gnt_idx];
    assign sel_lock  = Req_Lock[gnt_idx];
    assign sel_addr  = Req_Addr[gnt_idx*ADDR_W +: ADDR_W];
    assign sel_wdata = Req_Wdata[gnt_idx*DATA_W +: DATA_W];

    // Stage p1: buffer port and read tag; stage p2: tag aligned with buffer read data
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= ARB_OPEN;
            owner_q     <= '0;
            ptr_q       <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tag_p1_q    <= '0;
            tag_p2_q    <= '0;
        end else begin
            tag_p2_q       <= tag_p1_q;
            tag_p1_q.valid <= beat && !sel_write;
            tag_p1_q.id    <= (beat && !sel_write) ? TAG_ID_W'(gnt_idx) : '0;
            mem_read_q     <= beat && !sel_write;
            mem_write_q    <= beat && sel_write;
            if (beat) begin
                mem_addr_q  <= sel_addr;
                mem_wdata_q <= sel_wdata;
                ptr_q       <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                if (sel_lock) begin
                    state_q <= ARB_LOCKED;
                    owner_q <= gnt_idx;
                end else begin
                    state_q <= ARB_OPEN;
                end
            end
        end
    end

    logic unused_tag_bits;
    assign unused_tag_bits = ^tag_p2_q.id;

    assign Mem_Read       = mem_read_q;
    assign Mem_Write      = mem_write_q;
    assign Mem_Address    = mem_addr_q;
    assign Mem_Write_Data = mem_wdata_q;
    assign Rsp_Valid      = tag_p2_q.valid;
    assign Rsp_Id         = tag_p2_q.id[ID_W-1:0];
    // The buffer floats its read port when idle, so only pass data on a tagged cycle
    assign Rsp_Data       = tag_p2_q.valid ? Mem_Read_Data : '0;

endmodule

// File: tb/tb_mem_buffer_arbiter.sv
// Self-checking bench for mem_buffer_arbiter (two requesters) with a buffer model
// and a transaction-level reference model; honours MEM_BUFFER_ARB_PRIO_EN.
module tb_mem_buffer_arbiter;

    localparam int N = 2;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [1:0]  Req_Valid, Req_Write, Req_Lock, Req_Ready;
    logic [15:0] Req_Addr;
    logic [31:0] Req_Wdata;
    logic        Rsp_Valid;
    logic [0:0]  Rsp_Id;
    logic [15:0] Rsp_Data;
    logic        Mem_Read, Mem_Write;
    logic [7:0]  Mem_Address;
    logic [15:0] Mem_Write_Data, Mem_Read_Data;

    int errors = 0;
    int checks = 0;

    mem_buffer_arbiter #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(16)) dut (
        .Clk(Clk), .Rst(Rst),
        .Req_Valid(Req_Valid), .Req_Write(Req_Write), .Req_Lock(Req_Lock),
        .Req_Addr(Req_Addr), .Req_Wdata(Req_Wdata), .Req_Ready(Req_Ready),
        .Rsp_Valid(Rsp_Valid), .Rsp_Id(Rsp_Id), .Rsp_Data(Rsp_Data),
        .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Mem_Address(Mem_Address),
        .Mem_Write_Data(Mem_Write_Data), .Mem_Read_Data(Mem_Read_Data)
    );

    always #5 Clk = ~Clk;

    // Power-on buffer contents
    function automatic logic [15:0] init_val(input logic [7:0] a);
        return (a == 8'h05) ? 16'h1234 : {a, a ^ 8'hA5};
    endfunction

    // Synchronous single-port buffer; drives a junk pattern when not reading
    logic [15:0] bmem [256];
    logic [15:0] rd_q;
    always @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < 256; i++) bmem[i] <= init_val(8'(i));
            rd_q <= 16'hDEAD;
        end else begin
            if (Mem_Write) bmem[Mem_Address] <= Mem_Write_Data;
            rd_q <= Mem_Read ? bmem[Mem_Address] : 16'hDEAD;
        end
    end
    assign Mem_Read_Data = rd_q;

    // Reference model: who is granted, what lands on the port, what comes back
    int          m_ptr, m_owner;
    bit          m_locked;
    bit          e_rd, e_wr, e_v1, e_v2;
    int          e_id1, e_id2;
    logic [7:0]  e_addr;
    logic [15:0] e_wdata, e_d1, e_d2;
    logic [15:0] ref_mem [256];

    function automatic int model_grant();
        if (Rst) return -1;
        if (m_locked) return Req_Valid[m_owner] ? m_owner : -1;
`ifdef MEM_BUFFER_ARB_PRIO_EN
        for (int k = 0; k < N; k++) if (Req_Valid[k]) return k;
`else
        for (int k = 0; k < N; k++) if (Req_Valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
`endif
        return -1;
    endfunction

    function automatic logic [1:0] exp_ready();
        int g;
        g = model_grant();
        return (g < 0) ? 2'b00 : 2'(1 << g);
    endfunction

    task automatic model_tick();
        int g;
        logic [7:0] a;
        g = model_grant();
        if (Rst) begin
            m_ptr = 0; m_owner = 0; m_locked = 0;
            e_rd = 0; e_wr = 0; e_v1 = 0; e_v2 = 0; e_id1 = 0; e_id2 = 0;
            e_addr = '0; e_wdata = '0; e_d1 = '0; e_d2 = '0;
            for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        end else begin
            e_v2 = e_v1; e_id2 = e_id1; e_d2 = e_d1;
            e_rd = 0; e_wr = 0; e_v1 = 0; e_id1 = 0;
            if (g >= 0) begin
                a       = Req_Addr[g*8 +: 8];
                e_addr  = a;
                e_wdata = Req_Wdata[g*16 +: 16];
                if (Req_Write[g]) begin
                    e_wr = 1;
                    ref_mem[a] = e_wdata;
                end else begin
                    e_rd = 1; e_v1 = 1; e_id1 = g; e_d1 = ref_mem[a];
                end
                m_ptr = (g + 1) % N;
                if (Req_Lock[g]) begin m_locked = 1; m_owner = g; end
                else m_locked = 0;
            end
        end
    endtask

    task automatic step();
        model_tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        Req_Valid = '0; Req_Write = '0; Req_Lock = '0;
    endtask

    task automatic test_reset();
        Rst = 1; Req_Valid = 2'b11; Req_Write = 2'b01; Req_Lock = 2'b11;
        Req_Addr = 16'h1122; Req_Wdata = 32'h5555_AAAA;
        step(); step(); #1;
        checks++; if (Req_Ready !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", Req_Ready); end
        checks++; if (Rsp_Valid !== 1'b0 || Rsp_Id !== 1'b0 || Rsp_Data !== 16'h0) begin
            errors++; $display("FAIL reset_rsp got v=%b id=%0d d=%h exp 0/0/0", Rsp_Valid, Rsp_Id, Rsp_Data); end
        checks++; if (Mem_Read !== 1'b0 || Mem_Write !== 1'b0 || Mem_Address !== 8'h0 || Mem_Write_Data !== 16'h0) begin
            errors++; $display("FAIL reset_mem got r=%b w=%b a=%h d=%h exp all 0", Mem_Read, Mem_Write, Mem_Address, Mem_Write_Data); end
        Rst = 0; idle(); step();
    endtask

    task automatic test_single_read();
        Req_Valid = 2'b01; Req_Write = 2'b00; Req_Addr = 16'h0005; #1;
        checks++; if (Req_Ready !== 2'b01) begin errors++; $display("FAIL single_ready got=%b exp=01", Req_Ready); end
        step(); idle(); #1;
        checks++; if (Mem_Read !== 1'b1 || Mem_Write !== 1'b0 || Mem_Address !== 8'h05) begin
            errors++; $display("FAIL single_mem got r=%b w=%b a=%h exp 1/0/05", Mem_Read, Mem_Write, Mem_Address); end
        step();
        checks++; if (Rsp_Valid !== 1'b1 || Rsp_Id !== 1'b0 || Rsp_Data !== 16'h1234) begin
            errors++; $display("FAIL single_rsp got v=%b id=%0d d=%h exp 1/0/1234", Rsp_Valid, Rsp_Id, Rsp_Data); end
        step();
        checks++; if (Rsp_Valid !== 1'b0 || Rsp_Data !== 16'h0) begin
            errors++; $display("FAIL single_idle got v=%b d=%h exp 0/0000", Rsp_Valid, Rsp_Data); end
    endtask

    task automatic test_contention();
        int prev;
        prev = -1;
        for (int c = 0; c < 6; c++) begin
            Req_Valid = 2'b11; Req_Write = 2'b00; Req_Lock = 2'b00;
            Req_Addr = {4'h2, 4'(c), 4'h1, 4'(c)}; #1;
            checks++; if (Req_Ready !== exp_ready()) begin
                errors++; $display("FAIL contention_ready cyc=%0d got=%b exp=%b", c, Req_Ready, exp_ready()); end
`ifndef MEM_BUFFER_ARB_PRIO_EN
            checks++; if (prev >= 0 && Req_Ready === 2'(1 << prev)) begin
                errors++; $display("FAIL contention_alternate cyc=%0d got=%b exp other than last", c, Req_Ready); end
`endif
            prev = model_grant();
            step();
            checks++; if (Rsp_Valid !== e_v2 || Rsp_Id !== 1'(e_id2) || Rsp_Data !== (e_v2 ? e_d2 : 16'h0)) begin
                errors++; $display("FAIL contention_rsp cyc=%0d got v=%b id=%0d d=%h exp v=%b id=%0d d=%h",
                                   c, Rsp_Valid, Rsp_Id, Rsp_Data, e_v2, e_id2, e_d2); end
        end
        idle(); step(); step();
    endtask

    task automatic test_lock_burst();
        logic [1:0] vseq [6] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
        logic [1:0] lseq [6] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
        logic [1:0] rseq [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00};
        for (int c = 0; c < 6; c++) begin
            Req_Valid = vseq[c]; Req_Lock = lseq[c]; Req_Write = 2'b11;
            Req_Addr = 16'h3020; Req_Wdata = {16'hA000 + 16'(c), 16'hB000 + 16'(c)}; #1;
            checks++; if (Req_Ready !== rseq[c]) begin
                errors++; $display("FAIL lock_ready cyc=%0d got=%b exp=%b", c, Req_Ready, rseq[c]); end
            step();
        end
        // Owner going idle keeps the lock
        Req_Valid = 2'b10; Req_Lock = 2'b10; #1; step();
        Req_Valid = 2'b01; Req_Lock = 2'b00; #1;
        checks++; if (Req_Ready !== 2'b00) begin errors++; $display("FAIL lock_hold got=%b exp=00", Req_Ready); end
        step();
        Req_Valid = 2'b11; #1;
        checks++; if (Req_Ready !== 2'b10) begin errors++; $display("FAIL lock_owner got=%b exp=10", Req_Ready); end
        step(); idle(); step(); step();
    endtask

    task automatic test_write_read();
        Req_Valid = 2'b01; Req_Write = 2'b01; Req_Lock = 2'b00; Req_Addr = 16'h0010; Req_Wdata = 32'h0000_BEEF; #1;
        step();
        Req_Write = 2'b00; #1;
        checks++; if (Mem_Write !== 1'b1 || Mem_Read !== 1'b0 || Mem_Address !== 8'h10 || Mem_Write_Data !== 16'hBEEF) begin
            errors++; $display("FAIL wr_mem got w=%b r=%b a=%h d=%h exp 1/0/10/beef", Mem_Write, Mem_Read, Mem_Address, Mem_Write_Data); end
        step(); idle(); step();
        checks++; if (Rsp_Valid !== 1'b1 || Rsp_Data !== 16'hBEEF) begin
            errors++; $display("FAIL wr_then_rd got v=%b d=%h exp 1/beef", Rsp_Valid, Rsp_Data); end
        step();
    endtask

    task automatic test_reset_mid_read();
        Req_Valid = 2'b01; Req_Write = 2'b00; Req_Addr = 16'h0010; #1;
        step();
        Rst = 1; #1;
        checks++; if (Req_Ready !== 2'b00) begin errors++; $display("FAIL rstmid_ready got=%b exp=00", Req_Ready); end
        step(); idle();
        checks++; if (Rsp_Valid !== 1'b0 || Mem_Read !== 1'b0 || Mem_Address !== 8'h0) begin
            errors++; $display("FAIL rstmid_out got v=%b r=%b a=%h exp 0/0/00", Rsp_Valid, Mem_Read, Mem_Address); end
        Rst = 0; step();
        checks++; if (Rsp_Valid !== 1'b0) begin errors++; $display("FAIL rstmid_norsp got=%b exp=0", Rsp_Valid); end
        Req_Valid = 2'b01; Req_Addr = 16'h0010; #1; step(); idle(); step();
        checks++; if (Rsp_Valid !== 1'b1 || Rsp_Data !== init_val(8'h10)) begin
            errors++; $display("FAIL rstmid_reload got v=%b d=%h exp 1/%h", Rsp_Valid, Rsp_Data, init_val(8'h10)); end
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            Rst       = ($urandom_range(0, 59) == 0);
            Req_Valid = 2'($urandom);
            Req_Write = 2'($urandom);
            Req_Lock  = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            Req_Addr  = {4'h0, 4'($urandom), 4'h0, 4'($urandom)};
            Req_Wdata = $urandom;
            #1;
            checks++; if (Req_Ready !== exp_ready()) begin
                errors++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, Req_Ready, exp_ready()); end
            checks++; if (Mem_Read !== e_rd || Mem_Write !== e_wr || Mem_Address !== e_addr || Mem_Write_Data !== e_wdata) begin
                errors++; $display("FAIL rand_mem cyc=%0d got r=%b w=%b a=%h d=%h exp r=%b w=%b a=%h d=%h",
                                   c, Mem_Read, Mem_Write, Mem_Address, Mem_Write_Data, e_rd, e_wr, e_addr, e_wdata); end
            checks++; if (Rsp_Valid !== e_v2 || Rsp_Id !== 1'(e_id2) || Rsp_Data !== (e_v2 ? e_d2 : 16'h0)) begin
                errors++; $display("FAIL rand_rsp cyc=%0d got v=%b id=%0d d=%h exp v=%b id=%0d d=%h",
                                   c, Rsp_Valid, Rsp_Id, Rsp_Data, e_v2, e_id2, e_d2); end
            step();
        end
        Rst = 0; idle(); step(); step(); step();
    endtask

    initial begin
        Rst = 1; idle(); Req_Addr = '0; Req_Wdata = '0;
        #1;
        test_reset();
        test_single_read();
        test_contention();
        test_lock_burst();
        test_write_read();
        test_reset_mid_read();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
